// File: rtl/puf_response_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : puf_response_conditioner
// Description : Enables the PUF generator and waits for the ring to settle.
//               It then takes three snapshots of the response and
//               majority-votes them bit by bit into one stable response.
//               The voted response is streamed out as WORD_W-bit words over
//               a valid/ready handshake. The block also flags any bit that
//               disagreed between the snapshots.
// Ports       : clk, rst_n            - clock, async active-low reset
//               start, abort          - run request / synchronous cancel
//               ctrl_sel              - challenge value, latched on start
//               puf_enable            - generator enable (SETTLE/SAMPLE)
//               puf_control           - latched challenge to generator
//               puf_response          - generator output (clk-synchronous)
//               word_data/valid/last  - output word stream
//               word_ready            - downstream accept
//               busy, done, unstable  - status
// Revision    : 1.0 - initial release
// ============================================================================
module puf_response_conditioner #(
    parameter int RESP_W        = 1024,
    parameter int WORD_W        = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int GAP_CYCLES    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        ctrl_sel,
    output logic              puf_enable,
    output logic [1:0]        puf_control,
    input  logic [RESP_W-1:0] puf_response,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic              busy,
    output logic              done,
    output logic              unstable
);

    localparam int c_NWORDS = RESP_W / WORD_W;
    localparam int c_MAX_SG = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
    localparam int c_MAX_C  = (c_MAX_SG > c_NWORDS) ? c_MAX_SG : c_NWORDS;
    localparam int c_CW     = $clog2(c_MAX_C + 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETTLE = 3'd1;
    localparam logic [2:0] c_SAMPLE = 3'd2;
    localparam logic [2:0] c_STREAM = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   r_widx;
    logic              r_phase;     // 0: next capture is s1, 1: next is the third
    logic [1:0]        r_ctrl;
    logic              r_unstable;
    logic [RESP_W-1:0] r_s0;
    logic [RESP_W-1:0] r_s1;
    logic [RESP_W-1:0] r_vote;

    logic w_settle_hit;
    logic w_gap_hit;
    logic w_last_idx;

    assign w_settle_hit = (r_cnt == c_CW'(SETTLE_CYCLES - 1));
    assign w_gap_hit    = (r_cnt == c_CW'(GAP_CYCLES - 1));
    assign w_last_idx   = (r_widx == c_CW'(c_NWORDS - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort dominates everything, including start in IDLE
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:   if (start) w_state_nxt = c_SETTLE;
                c_SETTLE: if (w_settle_hit) w_state_nxt = c_SAMPLE;
                c_SAMPLE: if (w_gap_hit && r_phase) w_state_nxt = c_STREAM;
                c_STREAM: if (word_ready && w_last_idx) w_state_nxt = c_DONE;
                c_DONE:   w_state_nxt = c_IDLE;
                default:  w_state_nxt = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        puf_enable = 1'b0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            c_SETTLE, c_SAMPLE: begin
                puf_enable = 1'b1;
                busy       = 1'b1;
            end
            c_STREAM: begin
                word_valid = 1'b1;
                word_last  = w_last_idx;
                busy       = 1'b1;
            end
            c_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign puf_control = r_ctrl;
    assign unstable    = r_unstable;
    assign word_data   = r_vote[r_widx * WORD_W +: WORD_W];

    // ------------------------------------------------------------------
    // Datapath: timing counter, snapshots, vote, word index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_widx     <= '0;
            r_phase    <= 1'b0;
            r_ctrl     <= 2'b00;
            r_unstable <= 1'b0;
            r_s0       <= '0;
            r_s1       <= '0;
            r_vote     <= '0;
        end else if (abort) begin
            r_cnt      <= '0;
            r_widx     <= '0;
            r_phase    <= 1'b0;
            r_unstable <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_ctrl     <= ctrl_sel;
                        r_unstable <= 1'b0;
                        r_cnt      <= '0;
                        r_phase    <= 1'b0;
                        r_widx     <= '0;
                    end
                end
                c_SETTLE: begin
                    if (w_settle_hit) begin
                        r_s0  <= puf_response;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_SAMPLE: begin
                    if (w_gap_hit) begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            r_s1    <= puf_response;
                            r_phase <= 1'b1;
                        end else begin
                            // Third snapshot is used straight from the input
                            r_vote     <= (r_s0 & r_s1) | (r_s1 & puf_response) | (r_s0 & puf_response);
                            r_unstable <= |((r_s0 ^ r_s1) | (r_s1 ^ puf_response));
                            r_widx     <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_STREAM: begin
                    // Index parks on the final word so word_data never
                    // selects beyond the vote register.
                    if (word_ready && !w_last_idx) begin
                        r_widx <= r_widx + c_CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
